// File: rtl/div_seq.sv
// div_seq: sequences one signed/unsigned division through an external 32-step unsigned
// Divider, with zero-divisor and large-unsigned-divisor shortcuts and Euclidean sign fix-up.
`timescale 1ns/1ps
`default_nettype none

module div_seq #(
   parameter int W       = 32,
   parameter int TIMEOUT = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sgn,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         busy,
   output logic         done,
   output logic         dz,
   output logic         err,
   output logic [W-1:0] quot,
   output logic [W-1:0] rem,
   output logic         div_run,
   output logic [W-1:0] div_x,
   output logic [W-1:0] div_y,
   input  logic         div_stall,
   input  logic [W-1:0] div_quot,
   input  logic [W-1:0] div_rem
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t        state_q;
   logic          busy_q, done_q, dz_q, err_q, run_q;
   logic          sx_q, sy_q;
   logic [CW-1:0] c_q;
   logic [W-1:0]  quot_q, rem_q, div_x_q, div_y_q, q0_q, r0_q;

   // Start-time decode, evaluated against the live inputs in IDLE
   logic          sx_d, sy_d, y_zero_d, ufast_d, uge_d;
   logic [W-1:0]  abs_x_d, abs_y_d;

   assign sx_d     = sgn & x[W-1];
   assign sy_d     = sgn & y[W-1];
   assign abs_x_d  = sx_d ? -x : x;
   assign abs_y_d  = sy_d ? -y : y;
   assign y_zero_d = (y == '0);
   assign ufast_d  = ~sgn & y[W-1];
   assign uge_d    = (x >= y);

   // Euclidean correction: a negative dividend with nonzero remainder rounds the magnitude up
   logic          adj_d;
   logic [W-1:0]  qm_d, qfix_d, rfix_d;

   assign adj_d  = sx_q & (r0_q != '0);
   assign qm_d   = q0_q + {{(W-1){1'b0}}, adj_d};
   assign rfix_d = adj_d ? (div_y_q - r0_q) : r0_q;
   assign qfix_d = (sx_q ^ sy_q) ? -qm_d : qm_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         err_q   <= 1'b0;
         run_q   <= 1'b0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         c_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         div_x_q <= '0;
         div_y_q <= '0;
         q0_q    <= '0;
         r0_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (y_zero_d) begin
                     quot_q <= '1;
                     rem_q  <= x;
                     dz_q   <= 1'b1;
                     err_q  <= 1'b0;
                     done_q <= 1'b1;
                  end else if (ufast_d) begin
                     quot_q <= {{(W-1){1'b0}}, uge_d};
                     rem_q  <= uge_d ? (x - y) : x;
                     dz_q   <= 1'b0;
                     err_q  <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     sx_q    <= sx_d;
                     sy_q    <= sy_d;
                     div_x_q <= abs_x_d;
                     div_y_q <= abs_y_d;
                     dz_q    <= 1'b0;
                     err_q   <= 1'b0;
                     c_q     <= '0;
                     run_q   <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               c_q <= c_q + 1'b1;
               if (!div_stall) begin
                  q0_q    <= div_quot;
                  r0_q    <= div_rem;
                  run_q   <= 1'b0;
                  state_q <= S_FIX;
               end else if (c_q == C_LAST) begin
                  err_q   <= 1'b1;
                  quot_q  <= '0;
                  rem_q   <= '0;
                  done_q  <= 1'b1;
                  run_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_FIX: begin
               quot_q  <= qfix_d;
               rem_q   <= rfix_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               run_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign dz      = dz_q;
   assign err     = err_q;
   assign quot    = quot_q;
   assign rem     = rem_q;
   assign div_run = run_q;
   assign div_x   = div_x_q;
   assign div_y   = div_y_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq with a behavioural 32-step Divider model.
`timescale 1ns/1ps
`default_nettype none

module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic [31:0] x = '0;
   logic [31:0] y = '0;
   logic        busy, done, dz, err, div_run, div_stall;
   logic [31:0] quot, rem, div_x, div_y, div_quot, div_rem;

   div_seq #(.W(32), .TIMEOUT(40)) dut (
      .clk(clk), .rst(rst), .start(start), .sgn(sgn), .x(x), .y(y),
      .busy(busy), .done(done), .dz(dz), .err(err), .quot(quot), .rem(rem),
      .div_run(div_run), .div_x(div_x), .div_y(div_y),
      .div_stall(div_stall), .div_quot(div_quot), .div_rem(div_rem)
   );

   always #5 clk = ~clk;

   // Divider model: stall drops on the 32nd run cycle, step counter wraps there
   int   s_mdl = 0;
   logic force_stall = 1'b0;
   always @(posedge clk) s_mdl <= div_run ? ((s_mdl == 31) ? 0 : s_mdl + 1) : 0;
   assign div_stall = force_stall || (s_mdl != 31);
   assign div_quot  = (div_y != 0) ? div_x / div_y : '1;
   assign div_rem   = (div_y != 0) ? div_x % div_y : div_x;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        err;
      int          due;
   } exp_t;

   typedef struct {
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      bit          dz;
      int          lat;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   run_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (div_run === 1'b1) run_cnt <= run_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("quot", quot, mon_e.q);
            chk("rem", rem, mon_e.r);
            chk("dz", {31'b0, dz}, {31'b0, mon_e.dz});
            chk("err", {31'b0, err}, {31'b0, mon_e.err});
            chk("busy_at_done", {31'b0, busy}, 32'd0);
            chk("latency_cycle", 32'(cyc), 32'(mon_e.due));
         end
      end
   end

   // Called at a negedge; leaves start high for exactly one cycle, then scrambles inputs
   task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input bit edz, input bit eerr, input int lat);
      exp_t e;
      sgn   = s;
      x     = a;
      y     = b;
      start = 1'b1;
      e.q = eq; e.r = er; e.dz = edz; e.err = eerr; e.due = cyc + lat;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      sgn   = ~s;
      x     = ~a;
      y     = ~b;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output bit edz, output int lat);
      longint na, nb, qq, rr;
      edz = 1'b0;
      lat = 34;
      if (b == 0) begin
         q = '1; r = a; edz = 1'b1; lat = 1;
      end else if (!s) begin
         q = a / b; r = a % b;
         if (b[31]) lat = 1;
      end else begin
         na = longint'($signed(a));
         nb = longint'($signed(b));
         qq = na / nb;
         rr = na % nb;
         if (rr < 0) begin
            if (nb > 0) begin qq = qq - 1; rr = rr + nb; end
            else        begin qq = qq + 1; rr = rr - nb; end
         end
         q = qq[31:0];
         r = rr[31:0];
      end
   endfunction

   vec_t vt [11];

   initial begin
      int mark;
      int n;
      logic [31:0] rq, rr2;
      bit rdz, rs;
      int rlat;
      logic [31:0] ra, rb;

      vt = '{
         '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFC, 32'd1,        1'b0, 34},
         '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34},
         '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd4,        32'd1,        1'b0, 34},
         '{1'b1, 32'hFFFFFFF8, 32'd2,        32'hFFFFFFFC, 32'd0,        1'b0, 34},
         '{1'b0, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, 1},
         '{1'b0, 32'hFFFFFFFF, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1},
         '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 34},
         '{1'b0, 32'd256,      32'd7,        32'd36,       32'd4,        1'b0, 34},
         '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34},
         '{1'b0, 32'd5,        32'h80000001, 32'd0,        32'd5,        1'b0, 1},
         '{1'b1, 32'hFFFFFFF9, 32'h80000000, 32'd1,        32'h7FFFFFF9, 1'b0, 34}
      };

      // Reset state
      #12;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_dz", {31'b0, dz}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_run", {31'b0, div_run}, 32'd0);
      chk("rst_quot", quot, 32'd0);
      chk("rst_rem", rem, 32'd0);
      chk("rst_div_x", div_x, 32'd0);
      chk("rst_div_y", div_y, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // First op: also look at the Divider operands and run length
      mark = run_cnt;
      issue(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFC, 32'd1, 1'b0, 1'b0, 34);
      chk("run_div_run", {31'b0, div_run}, 32'd1);
      chk("run_busy", {31'b0, busy}, 32'd1);
      chk("run_div_x", div_x, 32'd7);
      chk("run_div_y", div_y, 32'd2);
      drain();
      chk("run_length", 32'(run_cnt - mark), 32'd32);

      foreach (vt[i]) begin
         mark = run_cnt;
         issue(vt[i].s, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, 1'b0, vt[i].lat);
         drain();
         chk("vec_run_cycles", 32'(run_cnt - mark), (vt[i].lat == 34) ? 32'd32 : 32'd0);
      end

      // Divider never releases stall
      force_stall = 1'b1;
      issue(1'b1, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b1, 41);
      drain();
      force_stall = 1'b0;
      chk("timeout_busy", {31'b0, busy}, 32'd0);

      // Asynchronous reset in the middle of RUN
      issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, 34);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_div_run", {31'b0, div_run}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      sb.delete();
      @(negedge clk);
      chk("abort_quot", quot, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, 34);
      drain();

      // start while busy is dropped
      issue(1'b0, 32'd50, 32'd7, 32'd7, 32'd1, 1'b0, 1'b0, 34);
      repeat (4) @(negedge clk);
      sgn = 1'b0; x = 32'd99; y = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (40) @(negedge clk);

      // start in the done cycle is taken
      issue(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF1, 32'd5, 1'b0, 1'b0, 34);
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_wait: got done=%b expected 1 within 60 cycles", done);
      end
      issue(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b0, 34);
      drain();

      // Random mix against the reference model
      for (int k = 0; k < 150; k++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
         ref_div(rs, ra, rb, rq, rr2, rdz, rlat);
         issue(rs, ra, rb, rq, rr2, rdz, 1'b0, rlat);
         drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1);
   end

endmodule

`default_nettype wire
